// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit
//
// Forwarding-select and load-use hazard control for a 5-stage MIPS pipeline.
// The unit keeps a private shadow of the destination information of the
// instructions currently in EX and MEM. Because of this, it only needs the
// decode fields of the instruction in ID.
//
// Ports
//   i_clk         pipeline clock, rising-edge active
//   i_reset_n     asynchronous active-low reset
//   i_Enable      pipeline advance; 0 freezes all state (debug hold)
//   i_Id_Valid    ID holds a real instruction (0 = bubble / flushed)
//   i_Id_Rs/Rt    source register fields of the ID instruction
//   i_Id_UsesRs/Rt ID instruction actually reads rs / rt
//   i_Id_WriteReg resolved destination register of the ID instruction
//   i_Id_RegWrite ID instruction writes the register file
//   i_Id_MemRead  ID instruction is a load
//   o_ForwardA/B  registered ALU operand mux selects, valid during EX
//   o_Stall       combinational load-use stall (hold PC, IF/ID; bubble ID/EX)

module forwarding_hazard_unit #(
  parameter int unsigned     REG_ADDR_W = 5,
  parameter logic [1:0]      FWD_NONE   = 2'b00,
  parameter logic [1:0]      FWD_WB     = 2'b01,
  parameter logic [1:0]      FWD_MEM    = 2'b10
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_Enable,
  input  logic                  i_Id_Valid,
  input  logic [REG_ADDR_W-1:0] i_Id_Rs,
  input  logic [REG_ADDR_W-1:0] i_Id_Rt,
  input  logic                  i_Id_UsesRs,
  input  logic                  i_Id_UsesRt,
  input  logic [REG_ADDR_W-1:0] i_Id_WriteReg,
  input  logic                  i_Id_RegWrite,
  input  logic                  i_Id_MemRead,
  output logic [1:0]            o_ForwardA,
  output logic [1:0]            o_ForwardB,
  output logic                  o_Stall
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } slot_t;

  slot_t      ex_q,    ex_d;
  slot_t      mem_q,   mem_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic       stall;

  // A slot can supply register r only if it will write r. Register 0 is
  // hard-wired to zero, so it never matches.
  function automatic logic slot_match(input slot_t s,
                                      input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != '0);
  endfunction

  // The EX producer is checked first because it is the most recent writer.
  // If it matches, it shadows any older value in MEM.
  function automatic logic [1:0] fwd_sel(input slot_t ex_s,
                                         input slot_t mem_s,
                                         input logic [REG_ADDR_W-1:0] r,
                                         input logic uses);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (uses) begin
      if (slot_match(ex_s, r)) begin
        sel = FWD_MEM;
      end else if (slot_match(mem_s, r)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // A load in EX cannot forward until its data returns. Any ID consumer of
  // that load must therefore wait one cycle. The stall is gated by i_Enable,
  // so a debug hold never looks like a stall to the rest of the pipeline.
  always_comb begin
    stall = 1'b0;
    if (i_Enable && i_Id_Valid && ex_q.valid && ex_q.memread &&
        ex_q.regwrite && (ex_q.dst != '0)) begin
      stall = (i_Id_UsesRs && (ex_q.dst == i_Id_Rs)) ||
              (i_Id_UsesRt && (ex_q.dst == i_Id_Rt));
    end
  end

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;

    if (i_Enable) begin
      mem_d = ex_q;

      if (stall || !i_Id_Valid) begin
        ex_d    = '0;
        fwd_a_d = FWD_NONE;
        fwd_b_d = FWD_NONE;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.dst      = i_Id_WriteReg;
        ex_d.regwrite = i_Id_RegWrite;
        ex_d.memread  = i_Id_MemRead;
        fwd_a_d       = fwd_sel(ex_q, mem_q, i_Id_Rs, i_Id_UsesRs);
        fwd_b_d       = fwd_sel(ex_q, mem_q, i_Id_Rt, i_Id_UsesRt);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign o_ForwardA = fwd_a_q;
  assign o_ForwardB = fwd_b_q;
  assign o_Stall    = stall;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       id_v;
  logic [4:0] id_rs, id_rt, id_wr;
  logic       id_urs, id_urt, id_rw, id_mr;
  logic [1:0] fa, fb;
  logic       stall;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // reference shadow of the EX/MEM slots and of the forward registers
  logic       m_ex_v, m_ex_rw, m_ex_mr, m_mem_v, m_mem_rw, m_mem_mr;
  logic [4:0] m_ex_dst, m_mem_dst;
  logic [1:0] m_fa, m_fb;
  logic [3:0] sb_q[$];
  logic       last_stall;

  forwarding_hazard_unit #(.REG_ADDR_W(5)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_Enable(en), .i_Id_Valid(id_v),
    .i_Id_Rs(id_rs), .i_Id_Rt(id_rt), .i_Id_UsesRs(id_urs),
    .i_Id_UsesRt(id_urt), .i_Id_WriteReg(id_wr), .i_Id_RegWrite(id_rw),
    .i_Id_MemRead(id_mr), .o_ForwardA(fa), .o_ForwardB(fb), .o_Stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex_v = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_dst = 0;
    m_mem_v = 0; m_mem_rw = 0; m_mem_mr = 0; m_mem_dst = 0;
    m_fa = 2'b00; m_fb = 2'b00;
    sb_q.delete();
  endtask

  function automatic logic [1:0] msel(input logic [4:0] r, input logic u);
    if (!u || r == 5'd0) return 2'b00;
    if (m_ex_v && m_ex_rw && m_ex_dst == r) return 2'b10;
    if (m_mem_v && m_mem_rw && m_mem_dst == r) return 2'b01;
    return 2'b00;
  endfunction

  // Present one ID instruction for one cycle and score the results.
  task automatic step(input logic e, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urs, input logic urt,
                      input logic [4:0] wr, input logic rw, input logic mr);
    logic       m_st;
    logic [3:0] got;
    @(negedge clk);
    en = e; id_v = v; id_rs = rs; id_rt = rt; id_urs = urs; id_urt = urt;
    id_wr = wr; id_rw = rw; id_mr = mr;
    #1;
    m_st = e && v && m_ex_v && m_ex_mr && m_ex_rw && m_ex_dst != 0 &&
           ((urs && m_ex_dst == rs) || (urt && m_ex_dst == rt));
    last_stall = stall;
    check("stall", {3'b0, stall}, {3'b0, m_st});
    if (e) begin
      m_fa = (v && !m_st) ? msel(rs, urs) : 2'b00;
      m_fb = (v && !m_st) ? msel(rt, urt) : 2'b00;
      m_mem_v = m_ex_v; m_mem_rw = m_ex_rw; m_mem_mr = m_ex_mr;
      m_mem_dst = m_ex_dst;
      if (m_st || !v) begin
        m_ex_v = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_dst = 0;
      end else begin
        m_ex_v = 1; m_ex_rw = rw; m_ex_mr = mr; m_ex_dst = wr;
      end
    end
    sb_q.push_back({m_fa, m_fb});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 4'h1, 4'h0);
    end else begin
      got = sb_q.pop_front();
      check("fwd_ab", {fa, fb}, got);
    end
  endtask

  task automatic nop();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    last_stall = 0;
    en = 1; id_v = 1; id_rs = 5'd3; id_rt = 5'd3; id_urs = 1; id_urt = 1;
    id_wr = 5'd3; id_rw = 1; id_mr = 1;
    rst_n = 0;
    #2;
    check("reset_out", {fa, fb}, 4'h0);
    check("reset_stall", {3'b0, stall}, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // add $3=$1+$2 ; sub $4=$3+$5 -> A from EX/MEM
    step(1, 1, 1, 2, 1, 1, 3, 1, 0);
    step(1, 1, 3, 5, 1, 1, 4, 1, 0);
    check("sub_A10_B00", {fa, fb}, 4'b1000);
    nop(); nop();

    // add $3 ; nop ; or $6=$7|$3 -> B from MEM/WB
    step(1, 1, 1, 2, 1, 1, 3, 1, 0);
    nop();
    step(1, 1, 7, 3, 1, 1, 6, 1, 0);
    check("or_A00_B01", {fa, fb}, 4'b0001);
    nop(); nop();

    // add $3 ; add $3 ; and $8=$3&$3 -> newest producer wins
    step(1, 1, 1, 2, 1, 1, 3, 1, 0);
    step(1, 1, 1, 2, 1, 1, 3, 1, 0);
    step(1, 1, 3, 3, 1, 1, 8, 1, 0);
    check("and_both10", {fa, fb}, 4'b1010);
    nop(); nop();

    // lw $9 ; add $10=$9+$9 -> one stall, then WB forwarding
    step(1, 1, 29, 9, 1, 0, 9, 1, 1);
    step(1, 1, 9, 9, 1, 1, 10, 1, 0);
    check("lu_stall1", {3'b0, last_stall}, 4'h1);
    check("lu_bubble", {fa, fb}, 4'h0);
    step(1, 1, 9, 9, 1, 1, 10, 1, 0);
    check("lu_stall_once", {3'b0, last_stall}, 4'h0);
    check("lu_both01", {fa, fb}, 4'b0101);
    nop(); nop();

    // $0 is never forwarded and never stalls
    step(1, 1, 1, 2, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 11, 1, 0);
    check("r0_fwd", {fa, fb}, 4'h0);
    nop(); nop();
    step(1, 1, 29, 0, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 1, 12, 1, 0);
    check("r0_nostall", {3'b0, last_stall}, 4'h0);
    nop(); nop();

    // debug hold during a pending forward
    step(1, 1, 1, 2, 1, 1, 3, 1, 0);
    repeat (3) begin
      step(0, 1, 3, 5, 1, 1, 4, 1, 0);
      check("hold_nostall", {3'b0, last_stall}, 4'h0);
    end
    step(1, 1, 3, 5, 1, 1, 4, 1, 0);
    check("hold_resume", {fa, fb}, 4'b1000);
    nop(); nop();

    // hold while a load-use condition is visible in ID
    step(1, 1, 29, 12, 1, 0, 12, 1, 1);
    repeat (3) begin
      step(0, 1, 12, 12, 1, 1, 13, 1, 0);
      check("hold_lu_nostall", {3'b0, last_stall}, 4'h0);
    end
    step(1, 1, 12, 12, 1, 1, 13, 1, 0);
    check("hold_lu_stall", {3'b0, last_stall}, 4'h1);
    step(1, 1, 12, 12, 1, 1, 13, 1, 0);
    check("hold_lu_wb", {fa, fb}, 4'b0101);
    nop(); nop();

    // asynchronous reset mid-cycle discards the in-flight producer
    step(1, 1, 1, 2, 1, 1, 3, 1, 0);
    step(1, 1, 3, 3, 1, 1, 4, 1, 0);
    #1 rst_n = 0;
    #1;
    check("arst_out", {fa, fb}, 4'h0);
    check("arst_stall", {3'b0, stall}, 4'h0);
    model_reset();
    #1 rst_n = 1;
    step(1, 1, 3, 4, 1, 1, 5, 1, 0);
    check("arst_consumer", {fa, fb}, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Generates the 2-bit select codes for the two ALU-operand 3-input forwarding muxes in the EX stage.
- Generates the load-use stall/bubble control for the 5-stage MIPS pipeline.
- Keeps its own shadow of the EX and MEM stage destination info, so it needs only ID-stage decode fields.
- Select outputs are registered so they are stable for the whole EX cycle of the consuming instruction.

Parameters:
- REG_ADDR_W, 5, width of a register-file address.
- FWD_NONE, 2'b00, select code: operand from register file / ID-EX latch.
- FWD_WB, 2'b01, select code: operand from MEM/WB write-back data.
- FWD_MEM, 2'b10, select code: operand from EX/MEM ALU result.

Ports:
- i_clk  in  1  pipeline clock; all state updates on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_Enable  in  1  pipeline advance (0 = debug hold, all state frozen).
- i_Id_Valid  in  1  ID holds a real instruction (0 = bubble/flushed).
- i_Id_Rs  in  REG_ADDR_W  rs field of the ID instruction.
- i_Id_Rt  in  REG_ADDR_W  rt field of the ID instruction.
- i_Id_UsesRs  in  1  ID instruction reads rs.
- i_Id_UsesRt  in  1  ID instruction reads rt.
- i_Id_WriteReg  in  REG_ADDR_W  resolved destination (rd/rt/31).
- i_Id_RegWrite  in  1  ID instruction writes the register file.
- i_Id_MemRead  in  1  ID instruction is a load.
- o_ForwardA  out  2  select for ALU operand A mux, valid during EX.
- o_ForwardB  out  2  select for ALU operand B mux, valid during EX.
- o_Stall  out  1  hold PC and IF/ID, convert ID/EX to bubble (combinational).

Behaviour:
- State: two slots, EX and MEM. Each slot holds {valid, dst, regwrite, memread}. Plus registers o_ForwardA and o_ForwardB.
- Reset (asynchronous, i_reset_n=0):
  - Both slots invalid, all fields 0.
  - o_ForwardA = o_ForwardB = FWD_NONE.
  - o_Stall = 0 while in reset.
  - Reset may assert at any cycle; everything in flight is discarded with no partial update.
- A slot "matches" register r when: valid=1, regwrite=1, dst==r, and r!=0. Register 0 is never forwarded and never causes a stall.
- Load-use stall (combinational): o_Stall = i_Enable & i_Id_Valid & EX.valid & EX.memread & EX.regwrite & EX.dst!=0 & ((i_Id_UsesRs & EX.dst==i_Id_Rs) | (i_Id_UsesRt & EX.dst==i_Id_Rt)).
- On each rising edge with i_Enable=1:
  - MEM slot <= EX slot.
  - EX slot <= ID fields, or invalid if o_Stall=1 or i_Id_Valid=0.
  - o_ForwardA <= sel(i_Id_Rs, i_Id_UsesRs), and o_ForwardB <= sel(i_Id_Rt, i_Id_UsesRt), with:
    - sel = FWD_MEM if the current EX slot matches (that producer will sit in EX/MEM next cycle);
    - else FWD_WB if the current MEM slot matches (it will sit in MEM/WB);
    - else FWD_NONE.
  - EX priority over MEM is mandatory: the most recent producer wins.
  - Uses=0, a stall, or an invalid ID gives FWD_NONE on that operand.
- i_Enable=0: slots and forward registers hold. o_Stall forced 0 so the hold is not double-counted.
- Latency: selects appear exactly one cycle after the instruction is presented in ID, i.e. in its EX cycle. A stall costs exactly 1 cycle. After the stall the load sits in the MEM slot, so the consumer receives FWD_WB.
- No producer in both slots matching both operands creates a conflict: A and B are evaluated independently.
- The value 2'b11 is never driven.

Test Plan:
- Reset, then add $3=$1+$2, then sub $4=$3+$5 with i_Enable=1 each cycle -> the sub's EX cycle has o_ForwardA=2'b10, o_ForwardB=2'b00, and o_Stall never 1.
- add $3; nop; or $6=$7|$3 (rt=3) -> in the or's EX cycle o_ForwardB=2'b01, o_ForwardA=2'b00.
- add $3; add $3 (different value); and $8=$3&$3 -> both selects 2'b10 (the newest producer wins over the MEM-slot match).
- lw $9; add $10=$9+$9 -> o_Stall=1 for exactly one cycle while the add is in ID and the EX slot is a bubble. Then in the add's EX cycle both selects are 2'b01.
- Writes to $0 (add $0; add $11=$0+$0) -> selects 2'b00. Also lw $0 followed by a consumer of $0 -> o_Stall stays 0.
- Two cases:
  - Mid-sequence i_Enable=0 for 3 cycles during a pending forward -> selects and slots frozen, o_Stall=0; after re-enable the results are identical to the uninterrupted run.
  - i_reset_n pulsed low asynchronously mid-cycle -> outputs go 00/00/0 immediately, and the next consumer sees no forwarding.
